dcache_ctrl: RTL and testbench

DCACHE_CTRL -- requirements
Module: dcache_ctrl

---
 rtl/dcache_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// ---------------------------------------------------------------------------
// dcache_ctrl
//   Direct-mapped, write-back / write-allocate data cache controller.
//   2**INDEX_W lines of 256 bits (8 x 32-bit words), one valid, dirty and
//   tag entry per line. Hits are resolved combinationally in the same cycle.
//   A miss walks WBACK (dirty victim only) -> ALLOC -> DONE.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous reset, active low
//   cpu_req_i    CPU access request
//   cpu_write_i  1 = store, 0 = load
//   cpu_addr_i   byte address: [4:2] word, [4+INDEX_W:5] index, rest tag
//   cpu_data_i   store data
//   cpu_data_o   load data (0 unless a load completes this cycle)
//   cpu_stall_o  access not yet complete
//   mem_req_o    block request to memory (registered)
//   mem_write_o  1 = write-back, 0 = block read (registered)
//   mem_addr_o   block-aligned memory address (registered)
//   mem_data_o   write-back block (registered)
//   mem_data_i   refill block, valid in the mem_ack_i cycle
//   mem_ack_i    one-cycle completion pulse from memory
// ---------------------------------------------------------------------------
module dcache_ctrl #(
  parameter int unsigned INDEX_W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cpu_req_i,
  input  logic         cpu_write_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  output logic [31:0]  cpu_data_o,
  output logic         cpu_stall_o,
  output logic         mem_req_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
);

  localparam int unsigned LINES = 1 << INDEX_W;
  localparam int unsigned TAG_W = 27 - INDEX_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WBACK,
    S_ALLOC,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [LINES-1:0] valid_q, valid_d;
  logic [LINES-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [255:0]     data_q [LINES];

  logic         mem_req_q,   mem_req_d;
  logic         mem_write_q, mem_write_d;
  logic [31:0]  mem_addr_q,  mem_addr_d;
  logic [255:0] mem_data_q,  mem_data_d;
  logic [TAG_W-1:0] pend_tag_q, pend_tag_d;

  // Single write port shared by refill and store merge.
  logic               line_we;
  logic [INDEX_W-1:0] line_idx;
  logic [255:0]       line_wdata;
  logic               tag_we;
  logic [TAG_W-1:0]   tag_wdata;

  logic [2:0]         cpu_word;
  logic [INDEX_W-1:0] cpu_idx;
  logic [TAG_W-1:0]   cpu_tag;
  logic [INDEX_W-1:0] fill_idx;
  logic [TAG_W-1:0]   fill_tag;
  logic               hit;
  logic [255:0]       cur_line;
  logic [255:0]       merged_line;
  logic [31:0]        cur_word;
  logic               stall;
  logic [31:0]        rdata;
  logic               unused_addr_lsb;

  assign cpu_word        = cpu_addr_i[4:2];
  assign cpu_idx         = cpu_addr_i[4+INDEX_W:5];
  assign cpu_tag         = cpu_addr_i[31:5+INDEX_W];
  assign unused_addr_lsb = ^cpu_addr_i[1:0];

  // The refill target comes from the registered request address so the fill
  // still lands correctly if the CPU drops its request mid-miss.
  assign fill_idx = mem_addr_q[4+INDEX_W:5];
  assign fill_tag = mem_addr_q[31:5+INDEX_W];

  assign hit      = cpu_req_i & valid_q[cpu_idx] & (tag_q[cpu_idx] == cpu_tag);
  assign cur_line = data_q[cpu_idx];
  assign cur_word = cur_line[{cpu_word, 5'b0} +: 32];

  always_comb begin
    merged_line = cur_line;
    merged_line[{cpu_word, 5'b0} +: 32] = cpu_data_i;
  end

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    mem_req_d   = mem_req_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    pend_tag_d  = pend_tag_q;
    line_we     = 1'b0;
    line_idx    = cpu_idx;
    line_wdata  = merged_line;
    tag_we      = 1'b0;
    tag_wdata   = cpu_tag;
    stall       = 1'b0;
    rdata       = '0;

    case (state_q)
      S_IDLE: begin
        if (cpu_req_i) begin
          if (hit) begin
            if (cpu_write_i) begin
              line_we          = 1'b1;
              dirty_d[cpu_idx] = 1'b1;
            end else begin
              rdata = cur_word;
            end
          end else begin
            stall      = 1'b1;
            mem_req_d  = 1'b1;
            pend_tag_d = cpu_tag;
            if (valid_q[cpu_idx] && dirty_q[cpu_idx]) begin
              state_d     = S_WBACK;
              mem_write_d = 1'b1;
              mem_addr_d  = {tag_q[cpu_idx], cpu_idx, 5'b0};
              mem_data_d  = cur_line;
            end else begin
              state_d     = S_ALLOC;
              mem_write_d = 1'b0;
              mem_addr_d  = {cpu_tag, cpu_idx, 5'b0};
            end
          end
        end
      end

      S_WBACK: begin
        stall = 1'b1;
        if (mem_ack_i) begin
          // Request stays high straight into the refill; only direction and
          // tag change on this edge.
          state_d     = S_ALLOC;
          mem_write_d = 1'b0;
          mem_addr_d  = {pend_tag_q, fill_idx, 5'b0};
        end
      end

      S_ALLOC: begin
        stall = 1'b1;
        if (mem_ack_i) begin
          state_d           = S_DONE;
          mem_req_d         = 1'b0;
          mem_write_d       = 1'b0;
          line_we           = 1'b1;
          line_idx          = fill_idx;
          line_wdata        = mem_data_i;
          tag_we            = 1'b1;
          tag_wdata         = fill_tag;
          valid_d[fill_idx] = 1'b1;
          dirty_d[fill_idx] = 1'b0;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        // The freshly filled line now hits; a dropped request does nothing.
        if (hit) begin
          if (cpu_write_i) begin
            line_we          = 1'b1;
            dirty_d[cpu_idx] = 1'b1;
          end else begin
            rdata = cur_word;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      pend_tag_q  <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      mem_req_q   <= mem_req_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      pend_tag_q  <= pend_tag_d;
    end
  end

  // Tag and data arrays carry no reset; cleared valid bits mask them.
  always_ff @(posedge clk_i) begin
    if (line_we) begin
      data_q[line_idx] <= line_wdata;
    end
    if (tag_we) begin
      tag_q[line_idx] <= tag_wdata;
    end
  end

  // Reset forces the combinational CPU outputs low as well.
  assign cpu_stall_o = rst_i & stall;
  assign cpu_data_o  = rst_i ? rdata : '0;
  assign mem_req_o   = mem_req_q;
  assign mem_write_o = mem_write_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_data_o  = mem_data_q;

endmodule

// File: tb/tb_dcache_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dcache_ctrl
//   Drives CPU accesses and plays the memory side. A line-level cache model
//   (valid/dirty/tag/data per index) plus a block memory model decide, per
//   access, whether it hits and which memory transactions must follow; the
//   access task compares DUT outputs against that on every cycle.
// ---------------------------------------------------------------------------
module tb_dcache_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cpu_req_i;
  logic         cpu_write_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_req_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  dcache_ctrl #(.INDEX_W(4)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_write_i (cpu_write_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_data_i  (cpu_data_i),
    .cpu_data_o  (cpu_data_o),
    .cpu_stall_o (cpu_stall_o),
    .mem_req_o   (mem_req_o),
    .mem_write_o (mem_write_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .mem_data_i  (mem_data_i),
    .mem_ack_i   (mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Cache model
  bit           m_valid [16];
  bit           m_dirty [16];
  logic [22:0]  m_tag   [16];
  logic [255:0] m_data  [16];

  // Memory model, keyed by block number (address >> 5)
  logic [255:0] mem_store [int unsigned];

  // Observations from the most recent access
  int           last_stall;
  int           last_nrd;
  int           last_nwr;
  logic [31:0]  last_rdata;
  logic [31:0]  last_rd_addr;
  logic [31:0]  last_wr_addr;
  logic [255:0] last_wr_data;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [255:0] mem_default(input int unsigned blk);
    logic [255:0] b;
    for (int i = 0; i < 8; i++) begin
      b[i*32 +: 32] = (blk * 32'h9E3779B1) ^ (32'h01010101 * (i + 1));
    end
    return b;
  endfunction

  function automatic logic [255:0] mem_rd(input int unsigned blk);
    if (mem_store.exists(blk)) return mem_store[blk];
    return mem_default(blk);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  // One CPU access, starting and ending just after a falling edge.
  // lat_* = cycles the request is high up to and including the ack cycle.
  // drop_cyc > 0 drops cpu_req_i at that cycle of a miss.
  task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int lat_w, input int lat_r, input int drop_cyc);
    logic [3:0]   idx;
    logic [22:0]  tag;
    int           w;
    bit           hit;
    int           n_txn;
    bit           txn_wr   [2];
    logic [31:0]  txn_addr [2];
    logic [255:0] txn_data [2];
    int           txn_lat  [2];
    int           phase;
    int           t;
    int           cnt;
    bit           finished;
    bit           req_done;
    logic [255:0] fill;
    logic [255:0] garbage;
    logic [31:0]  exp_rd;
    int unsigned  blk;

    idx = addr[8:5];
    tag = addr[31:9];
    w   = int'(addr[4:2]);
    hit = m_valid[idx] && (m_tag[idx] == tag);
    n_txn = 0;
    if (!hit) begin
      if (m_valid[idx] && m_dirty[idx]) begin
        txn_wr[0]   = 1'b1;
        txn_addr[0] = {m_tag[idx], idx, 5'b0};
        txn_data[0] = m_data[idx];
        txn_lat[0]  = lat_w;
        n_txn = 1;
      end
      txn_wr[n_txn]   = 1'b0;
      txn_addr[n_txn] = {tag, idx, 5'b0};
      txn_data[n_txn] = '0;
      txn_lat[n_txn]  = lat_r;
      n_txn++;
    end
    fill       = m_data[idx];
    req_done   = 1'b1;
    last_stall = 0;
    last_nrd   = 0;
    last_nwr   = 0;
    last_rdata = '0;

    cpu_req_i   = 1'b1;
    cpu_write_i = wr;
    cpu_addr_i  = addr;
    cpu_data_i  = wdata;
    phase    = hit ? 2 : 0;
    t        = 0;
    cnt      = 0;
    finished = 1'b0;

    for (int c = 0; c < 200 && !finished; c++) begin
      if (!hit && drop_cyc > 0 && c == drop_cyc) cpu_req_i = 1'b0;
      for (int k = 0; k < 8; k++) garbage[k*32 +: 32] = $urandom;
      mem_ack_i  = 1'b0;
      mem_data_i = garbage;
      #1;
      if (cpu_stall_o === 1'b1) last_stall++;
      case (phase)
        0: begin
          chk("miss_stall", cpu_stall_o, 1);
          chk("miss_req", mem_req_o, 0);
          chk("miss_rdata", cpu_data_o, 0);
          phase = 1;
        end
        1: begin
          chk("mem_stall", cpu_stall_o, 1);
          chk("mem_req", mem_req_o, 1);
          chk("mem_write", mem_write_o, txn_wr[t]);
          chk("mem_addr", mem_addr_o, txn_addr[t]);
          chk("mem_cpu_rdata", cpu_data_o, 0);
          if (txn_wr[t]) chk("wb_data", mem_data_o, txn_data[t]);
          cnt++;
          if (cnt >= txn_lat[t]) begin
            mem_ack_i = 1'b1;
            blk = txn_addr[t] >> 5;
            if (txn_wr[t]) begin
              mem_store[blk] = txn_data[t];
              last_nwr++;
              last_wr_addr = mem_addr_o;
              last_wr_data = mem_data_o;
            end else begin
              fill       = mem_rd(blk);
              mem_data_i = fill;
              last_nrd++;
              last_rd_addr = mem_addr_o;
            end
            t++;
            cnt = 0;
            if (t == n_txn) phase = 2;
          end
        end
        default: begin
          req_done = cpu_req_i;
          exp_rd = (req_done && !wr) ? fill[w*32 +: 32] : 32'h0;
          chk("done_stall", cpu_stall_o, 0);
          chk("done_req", mem_req_o, 0);
          chk("done_rdata", cpu_data_o, exp_rd);
          last_rdata = cpu_data_o;
          mem_ack_i  = 1'($urandom % 2);  // must be ignored here
          finished   = 1'b1;
        end
      endcase
      @(negedge clk_i);
    end
    mem_ack_i = 1'b0;
    if (!finished) begin
      checks++;
      errors++;
      $display("FAIL access_timeout: addr %0h did not complete", addr);
    end

    if (!hit) begin
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tag;
      m_data[idx]  = fill;
    end
    if (req_done && wr) begin
      m_data[idx][w*32 +: 32] = wdata;
      m_dirty[idx] = 1'b1;
    end
  endtask

  task automatic idle_cycle();
    cpu_req_i   = 1'b0;
    cpu_write_i = 1'($urandom % 2);
    cpu_addr_i  = $urandom;
    mem_ack_i   = 1'($urandom % 2);
    #1;
    chk("idle_stall", cpu_stall_o, 0);
    chk("idle_req", mem_req_o, 0);
    chk("idle_rdata", cpu_data_o, 0);
    @(negedge clk_i);
    mem_ack_i = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    a[31:9] = 23'($urandom_range(0, 3));
    a[8:5]  = 4'($urandom_range(0, 7));
    return a;
  endfunction

  initial begin
    logic [255:0] blk_v;

    clear_model();
    rst_i       = 1'b0;
    cpu_req_i   = 1'b1;   // a would-be miss while reset is held
    cpu_write_i = 1'b0;
    cpu_addr_i  = 32'h0000_0104;
    cpu_data_i  = '0;
    mem_ack_i   = 1'b1;
    mem_data_i  = '1;
    #2;
    chk("rst_stall", cpu_stall_o, 0);
    chk("rst_rdata", cpu_data_o, 0);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_mem_write", mem_write_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_mem_data", mem_data_o, 0);
    @(negedge clk_i);
    rst_i     = 1'b1;
    cpu_req_i = 1'b0;
    mem_ack_i = 1'b0;
    idle_cycle();

    // Cold load, read latency 3
    blk_v = mem_default(8);
    blk_v[63:32] = 32'hDEAD_BEEF;
    mem_store[8] = blk_v;
    access(1'b0, 32'h0000_0104, 32'h0, 1, 3, 0);
    chk("cold_stall_cycles", last_stall, 4);
    chk("cold_rdata", last_rdata, 32'hDEAD_BEEF);
    chk("cold_reads", last_nrd, 1);
    chk("cold_rd_addr", last_rd_addr, 32'h0000_0100);
    chk("cold_writes", last_nwr, 0);

    // Store hit, then load hit
    access(1'b1, 32'h0000_0104, 32'h1234_5678, 1, 1, 0);
    chk("st_hit_stall", last_stall, 0);
    chk("st_hit_mem", last_nrd + last_nwr, 0);
    access(1'b0, 32'h0000_0104, 32'h0, 1, 1, 0);
    chk("ld_hit_stall", last_stall, 0);
    chk("ld_hit_rdata", last_rdata, 32'h1234_5678);

    // Conflict load evicts the dirty line
    access(1'b0, 32'h0000_0304, 32'h0, 2, 2, 0);
    chk("evict_writes", last_nwr, 1);
    chk("evict_wr_addr", last_wr_addr, 32'h0000_0100);
    chk("evict_wr_word1", last_wr_data[63:32], 32'h1234_5678);
    chk("evict_reads", last_nrd, 1);
    chk("evict_rd_addr", last_rd_addr, 32'h0000_0300);
    chk("evict_stall_cycles", last_stall, 5);

    // Store miss to a clean line, then force it out to see the merge
    access(1'b1, 32'h0000_0020, 32'hA5A5_A5A5, 1, 2, 0);
    chk("stmiss_writes", last_nwr, 0);
    chk("stmiss_rd_addr", last_rd_addr, 32'h0000_0020);
    chk("stmiss_rdata", last_rdata, 32'h0);
    access(1'b0, 32'h0000_0220, 32'h0, 1, 1, 0);
    blk_v = mem_default(1);
    blk_v[31:0] = 32'hA5A5_A5A5;
    chk("stmiss_dirty_wb", last_nwr, 1);
    chk("stmiss_wb_addr", last_wr_addr, 32'h0000_0020);
    chk("stmiss_wb_data", last_wr_data, blk_v);

    // Reset during ALLOC cycle 2, then a stale ack
    cpu_req_i   = 1'b1;
    cpu_write_i = 1'b0;
    cpu_addr_i  = 32'h0000_0440;
    #1;
    chk("rabort_miss_stall", cpu_stall_o, 1);
    @(negedge clk_i);
    #1;
    chk("rabort_alloc1_req", mem_req_o, 1);
    chk("rabort_alloc1_write", mem_write_o, 0);
    @(negedge clk_i);
    #1;
    chk("rabort_alloc2_req", mem_req_o, 1);
    rst_i = 1'b0;
    #1;
    chk("rabort_req", mem_req_o, 0);
    chk("rabort_write", mem_write_o, 0);
    chk("rabort_stall", cpu_stall_o, 0);
    chk("rabort_addr", mem_addr_o, 0);
    @(negedge clk_i);
    rst_i      = 1'b1;
    cpu_req_i  = 1'b0;
    mem_ack_i  = 1'b1;
    mem_data_i = '1;
    #1;
    chk("rabort_ack_req", mem_req_o, 0);
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    #1;
    chk("rabort_after_ack_req", mem_req_o, 0);
    clear_model();
    access(1'b0, 32'h0000_0440, 32'h0, 1, 2, 0);
    chk("rabort_remiss_stall", last_stall, 3);
    chk("rabort_remiss_reads", last_nrd, 1);

    // Request dropped during ALLOC of a store miss
    access(1'b1, 32'h0000_0040, 32'hCAFE_F00D, 1, 3, 2);
    chk("drop_reads", last_nrd, 1);
    chk("drop_rdata", last_rdata, 32'h0);
    access(1'b0, 32'h0000_0040, 32'h0, 1, 1, 0);
    blk_v = mem_default(2);
    chk("drop_hit_stall", last_stall, 0);
    chk("drop_word0_kept", last_rdata, blk_v[31:0]);
    access(1'b0, 32'h0000_0240, 32'h0, 1, 1, 0);
    chk("drop_line_clean", last_nwr, 0);

    // Randomized traffic over a small tag/index pool
    for (int n = 0; n < 300; n++) begin
      access(1'($urandom % 2), rand_addr(), $urandom,
             1 + int'($urandom % 4), 1 + int'($urandom % 4),
             ($urandom % 8 == 0) ? 1 + int'($urandom % 3) : 0);
      if ($urandom % 3 == 0) idle_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
